// File: rtl/multiplier_4bit.sv
// Iterative 4x4 unsigned shift-add multiplier: result and one-cycle done pulse 4 clocks after the accept edge.
// No backpressure; start is ignored while busy, and start in the done cycle is accepted for back-to-back use.
module multiplier_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] Product,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [3:0]  mplr_q, mplr_d;
    logic [7:0]  acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  acc_step;

    // Partial-product accumulate for the current multiplier bit; 15*15 fits in 8 bits.
    assign acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = {4'b0000, A};
                    mplr_d  = B;
                    acc_d   = 8'h00;
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                mcand_d = {mcand_q[6:0], 1'b0};
                mplr_d  = {1'b0, mplr_q[3:1]};
                cnt_d   = cnt_q + 2'd1;
                // Last iteration: publish the just-completed sum directly.
                if (cnt_q == 2'd3) begin
                    product_d = acc_step;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 8'h00;
            mplr_q    <= 4'h0;
            acc_q     <= 8'h00;
            cnt_q     <= 2'd0;
            product_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_multiplier_4bit.sv
// Scoreboard bench for multiplier_4bit: a cycle-level acceptance model queues expected products and due cycles.
module tb_multiplier_4bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] Product;
    logic       busy;
    logic       done;

    multiplier_4bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .Product (Product),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        int prod;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   free_cyc = 0;
    int   last_acc = -100;
    int   exp_prod = 0;
    int   errors   = 0;
    int   checks   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks = checks + 1;
        if (act != expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        exp_prod = 0;
        free_cyc = 0;
        last_acc = -100;
    endtask

    // Reference: an operation is accepted on any edge with start once the previous one
    // has reached its done cycle; its product appears exactly 4 edges later.
    always @(posedge clk) begin
        exp_t it;
        cyc = cyc + 1;
        if (rst) begin
            model_clear();
        end else if (start && cyc >= free_cyc) begin
            it.prod  = int'(A) * int'(B);
            it.due   = cyc + 4;
            sb.push_back(it);
            free_cyc = cyc + 5;
            last_acc = cyc;
        end
    end

    // Monitor: pops on each expected completion and checks every output every cycle.
    always @(negedge clk) begin
        exp_t it;
        logic exp_done;
        exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        chk("done", int'(done), int'(exp_done));
        chk("busy", int'(busy), int'(cyc >= last_acc && cyc <= last_acc + 3));
        if (exp_done) begin
            it = sb.pop_front();
            exp_prod = it.prod;
            if (done) chk("product", int'(Product), it.prod);
        end else begin
            chk("product_hold", int'(Product), exp_prod);
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("missed_done", cyc, sb[0].due);
            it = sb.pop_front();
        end
    end

    task automatic op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
        A = 4'($urandom);
        B = 4'($urandom);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_product", int'(Product), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        model_clear();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = 4'd0;
        B     = 4'd0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        op(4'd3, 4'd2);
        repeat (5) @(negedge clk);
        op(4'd15, 4'd1);
        repeat (4) @(negedge clk);
        op(4'd5, 4'd5);
        repeat (4) @(negedge clk);
        op(4'd15, 4'd15);
        repeat (4) @(negedge clk);
        op(4'd0, 4'd9);
        repeat (5) @(negedge clk);

        // Start while busy with different operands must be ignored.
        op(4'd3, 4'd2);
        @(negedge clk);
        start = 1'b1;
        A = 4'd7;
        B = 4'd7;
        @(negedge clk);
        start = 1'b0;
        A = 4'd7;
        B = 4'd7;
        repeat (5) @(negedge clk);

        // Reset two clocks into an operation aborts it without a done pulse.
        op(4'd5, 4'd5);
        reset_pulse();
        repeat (8) @(negedge clk);

        // Start held high with operands changing every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            A = 4'($urandom);
            B = 4'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);

        // All operand pairs, issued back to back in the done cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op(4'(a), 4'(b));
                repeat (3) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            A = 4'($urandom);
            B = 4'($urandom);
            if (i == 150) begin
                start = 1'b0;
                reset_pulse();
            end
        end
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
